// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between WriteBack (priority)
//   and a long-latency result source that enters through a small skid FIFO.
//   All register-file write outputs are registered.
//
//   Build option: define REGFILE_ARB_STARVE_GUARD_EN to add the starve counter
//   and the one-cycle FORCE state that stalls WriteBack so a long-waiting
//   FIFO head can drain. Without it, stall_wb is tied low and the FIFO drains
//   only in cycles where WriteBack is idle.
//
//   Handshake: an ext entry transfers on a rising edge where ext_valid and
//   ext_ready are both high; the source holds address/data stable while
//   ext_valid is high and ext_ready is low. ext_ready is !full, and is forced
//   low while reset is asserted.
//
//   Observing the FSM: stall_wb is high exactly when the FSM is in FORCE.
module regfile_write_arbiter #(
  parameter int DataWidth   = 32,
  parameter int FifoDepth   = 2,
  parameter int StarveLimit = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wb_write_enable,
  input  logic [4:0]           wb_write_address,
  input  logic [DataWidth-1:0] wb_write_data,
  input  logic                 ext_valid,
  input  logic [4:0]           ext_address,
  input  logic [DataWidth-1:0] ext_data,
  output logic                 ext_ready,
  output logic                 stall_wb,
  output logic                 reg_write_enable,
  output logic [4:0]           reg_write_address,
  output logic [DataWidth-1:0] reg_write_data
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(FifoDepth);

  // Reject illegal parameter sets at elaboration time.
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0 ||
      StarveLimit < 1 || StarveLimit > 15) begin : g_bad_params
    $error("regfile_write_arbiter: illegal FifoDepth/StarveLimit");
  end

  // FIFO storage and pointers
  logic [4:0]           mem_addr_q [FifoDepth];
  logic [4:0]           mem_addr_d [FifoDepth];
  logic [DataWidth-1:0] mem_data_q [FifoDepth];
  logic [DataWidth-1:0] mem_data_d [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic [4:0]           head_addr;
  logic [DataWidth-1:0] head_data;

  // Winner of the write port this cycle
  logic                 in_force;
  logic                 win_valid;
  logic [4:0]           win_addr;
  logic [DataWidth-1:0] win_data;

  // Output registers
  logic                 reg_write_enable_q, reg_write_enable_d;
  logic [4:0]           reg_write_address_q, reg_write_address_d;
  logic [DataWidth-1:0] reg_write_data_q, reg_write_data_d;

  // FIFO status, accept handshake and head-of-queue view
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FullCount);
    ext_ready  = !fifo_full && !reset;
    push       = ext_valid && ext_ready;
    head_addr  = mem_addr_q[rd_ptr_q];
    head_data  = mem_data_q[rd_ptr_q];
  end

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  typedef enum logic {
    IDLE  = 1'b0,
    FORCE = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;

  // Starve counter and FSM: count blocked edges, enter FORCE on reaching the limit
  always_comb begin
    state_d  = IDLE;
    starve_d = '0;
    if (state_q == IDLE && !fifo_empty && !pop) begin
      if (starve_q + 4'd1 == 4'(StarveLimit)) begin
        starve_d = '0;
        state_d  = FORCE;
      end else begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // FSM and starve counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign in_force = (state_q == FORCE);
  assign stall_wb = in_force;
`else
  assign in_force = 1'b0;
  assign stall_wb = 1'b0;
`endif

  // Grant: FORCE drains the head, else WriteBack, else the head if present
  always_comb begin
    pop       = 1'b0;
    win_valid = 1'b0;
    win_addr  = '0;
    win_data  = '0;
    if (in_force) begin
      pop       = !fifo_empty;
      win_valid = !fifo_empty;
      win_addr  = head_addr;
      win_data  = head_data;
    end else if (wb_write_enable) begin
      win_valid = 1'b1;
      win_addr  = wb_write_address;
      win_data  = wb_write_data;
    end else if (!fifo_empty) begin
      pop       = 1'b1;
      win_valid = 1'b1;
      win_addr  = head_addr;
      win_data  = head_data;
    end
  end

  // FIFO next state: write at the tail, advance the head on pop
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_addr_d[wr_ptr_q] = ext_address;
      mem_data_d[wr_ptr_q] = ext_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr_q <= '{default: '0};
      mem_data_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Register-file write: winner's fields, zeros when idle, no enable for x0
  always_comb begin
    reg_write_enable_d  = win_valid && (win_addr != 5'd0);
    reg_write_address_d = win_valid ? win_addr : '0;
    reg_write_data_d    = win_valid ? win_data : '0;
  end

  // Output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write_enable_q  <= 1'b0;
      reg_write_address_q <= '0;
      reg_write_data_q    <= '0;
    end else begin
      reg_write_enable_q  <= reg_write_enable_d;
      reg_write_address_q <= reg_write_address_d;
      reg_write_data_q    <= reg_write_data_d;
    end
  end

  assign reg_write_enable  = reg_write_enable_q;
  assign reg_write_address = reg_write_address_q;
  assign reg_write_data    = reg_write_data_q;

endmodule
